// File: rtl/tone_gen_poly.sv
// Square-wave note generator for one piano voice. It plays any chromatic note in octaves 0..7.
// Pitch changes and key release take effect only at period boundaries, so no pulse is truncated.
module tone_gen_poly #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_on,
  input  logic [3:0] note_sel,
  input  logic [2:0] octave,
  output logic       tone_out,
  output logic       active,
  output logic       edge_tick,
  output logic [3:0] cur_note
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Octave-4 half-period in clocks, rounded to nearest, from a frequency in centi-Hz.
  function automatic logic [CNT_W-1:0] hp4_calc(input longint unsigned f_chz);
    longint unsigned num;
    num = longint'(CLK_HZ) * 64'd100 + f_chz;
    return CNT_W'(num / (64'd2 * f_chz));
  endfunction

  localparam logic [CNT_W-1:0] HP4_C  = hp4_calc(64'd26163);
  localparam logic [CNT_W-1:0] HP4_CS = hp4_calc(64'd27718);
  localparam logic [CNT_W-1:0] HP4_D  = hp4_calc(64'd29366);
  localparam logic [CNT_W-1:0] HP4_DS = hp4_calc(64'd31113);
  localparam logic [CNT_W-1:0] HP4_E  = hp4_calc(64'd32963);
  localparam logic [CNT_W-1:0] HP4_F  = hp4_calc(64'd34923);
  localparam logic [CNT_W-1:0] HP4_FS = hp4_calc(64'd36999);
  localparam logic [CNT_W-1:0] HP4_G  = hp4_calc(64'd39200);
  localparam logic [CNT_W-1:0] HP4_GS = hp4_calc(64'd41530);
  localparam logic [CNT_W-1:0] HP4_A  = hp4_calc(64'd44000);
  localparam logic [CNT_W-1:0] HP4_AS = hp4_calc(64'd46616);
  localparam logic [CNT_W-1:0] HP4_B  = hp4_calc(64'd49388);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hp;
  logic             r_tone;
  logic             r_tick;
  logic [3:0]       r_note;

  logic [0:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_hp_d;
  logic             w_tone_d;
  logic             w_tick_d;
  logic [3:0]       w_note_d;
  logic [CNT_W-1:0] w_hp4;
  logic [CNT_W-1:0] w_hp;
  logic             w_valid;
  logic             w_last;

  always_comb begin
    w_hp4 = '0;
    case (note_sel)
      4'd0:    w_hp4 = HP4_C;
      4'd1:    w_hp4 = HP4_CS;
      4'd2:    w_hp4 = HP4_D;
      4'd3:    w_hp4 = HP4_DS;
      4'd4:    w_hp4 = HP4_E;
      4'd5:    w_hp4 = HP4_F;
      4'd6:    w_hp4 = HP4_FS;
      4'd7:    w_hp4 = HP4_G;
      4'd8:    w_hp4 = HP4_GS;
      4'd9:    w_hp4 = HP4_A;
      4'd10:   w_hp4 = HP4_AS;
      4'd11:   w_hp4 = HP4_B;
      default: w_hp4 = '0;
    endcase
  end

  assign w_hp    = (octave < 3'd4) ? (w_hp4 << (3'd4 - octave)) : (w_hp4 >> (octave - 3'd4));
  assign w_valid = key_on && (note_sel <= 4'd11);
  assign w_last  = (r_cnt == r_hp - 1'b1);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hp_d    = r_hp;
    w_tone_d  = r_tone;
    w_tick_d  = 1'b0;
    w_note_d  = r_note;
    case (r_state)
      ST_IDLE: begin
        w_cnt_d  = '0;
        w_tone_d = 1'b0;
        if (w_valid) begin
          w_hp_d    = w_hp;
          w_note_d  = note_sel;
          w_tone_d  = 1'b1;
          w_tick_d  = 1'b1;
          w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_cnt_d = '0;
          if (r_tone) begin
            w_tone_d = 1'b0;
            w_tick_d = 1'b1;
          end else if (w_valid) begin
            // Back-to-back period: reload pitch with no idle gap.
            w_hp_d   = w_hp;
            w_note_d = note_sel;
            w_tone_d = 1'b1;
            w_tick_d = 1'b1;
          end else begin
            w_tone_d  = 1'b0;
            w_state_d = ST_IDLE;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
        w_tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hp    <= '0;
      r_tone  <= 1'b0;
      r_tick  <= 1'b0;
      r_note  <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hp    <= w_hp_d;
      r_tone  <= w_tone_d;
      r_tick  <= w_tick_d;
      r_note  <= w_note_d;
    end
  end

  assign tone_out  = r_tone;
  assign active    = (r_state == ST_RUN);
  assign edge_tick = r_tick;
  assign cur_note  = r_note;

endmodule

// File: tb/tb_tone_gen_poly.sv
// Self-checking bench for tone_gen_poly: expected half-period segments are queued by the
// stimulus and checked by a monitor as each high/low half ends.
module tb_tone_gen_poly;

  localparam int unsigned CLK_HZ = 500_000;
  localparam int unsigned CNT_W  = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_on;
  logic [3:0] note_sel;
  logic [2:0] octave;
  logic       tone_out;
  logic       active;
  logic       edge_tick;
  logic [3:0] cur_note;

  always #5 clk = ~clk;

  tone_gen_poly #(
    .CLK_HZ(CLK_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_on   (key_on),
    .note_sel (note_sel),
    .octave   (octave),
    .tone_out (tone_out),
    .active   (active),
    .edge_tick(edge_tick),
    .cur_note (cur_note)
  );

  typedef struct {
    logic        level;
    logic [3:0]  note;
    int unsigned len;
  } seg_t;

  seg_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  function automatic int unsigned model_hp(int n, int oct);
    int unsigned     f[12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                               36999, 39200, 41530, 44000, 46616, 49388};
    longint unsigned hp4;
    hp4 = (longint'(CLK_HZ) * 100 + longint'(f[n])) / (2 * longint'(f[n]));
    if (oct < 4) return 32'(hp4 << (4 - oct));
    return 32'(hp4 >> (oct - 4));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_period(int n, int oct);
    seg_t s;
    s.level = 1'b1;
    s.note  = 4'(n);
    s.len   = model_hp(n, oct);
    exp_q.push_back(s);
    s.level = 1'b0;
    exp_q.push_back(s);
  endtask

  task automatic wait_q(int n, int max_cyc, string tag);
    int c = 0;
    while (exp_q.size() > n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(exp_q.size() <= n), 64'd1);
  endtask

  task automatic wait_idle(int max_cyc, string tag);
    int c = 0;
    while (active && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(active), 64'd0);
  endtask

  task automatic play(int n, int oct, int periods);
    int hp;
    hp       = int'(model_hp(n, oct));
    note_sel = 4'(n);
    octave   = 3'(oct);
    for (int i = 0; i < periods; i++) push_period(n, oct);
    key_on = 1'b1;
    wait_q(1, periods * 2 * hp + 20, "play_run");
    key_on = 1'b0;
    wait_idle(hp + 20, "play_release");
    chk("play_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: measures each high/low half while active and scores it against the queue.
  logic        prev_tone   = 1'b0;
  logic        prev_active = 1'b0;
  logic [3:0]  prev_note   = 4'd0;
  int unsigned run_len     = 0;

  always @(posedge clk) begin
    seg_t e;
    #1;
    if (mon_en) begin
      chk("edge_tick", 64'(edge_tick), 64'(tone_out != prev_tone));
      chk("tone_implies_active", 64'(tone_out && !active), 64'd0);
      if (prev_active && (!active || tone_out != prev_tone)) begin
        if (exp_q.size() == 0) begin
          chk("seg_queue_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("seg_level", 64'(prev_tone), 64'(e.level));
          chk("seg_len", 64'(run_len), 64'(e.len));
          chk("seg_note", 64'(prev_note), 64'(e.note));
        end
      end
      if (active && (!prev_active || tone_out != prev_tone)) run_len = 1;
      else run_len++;
    end
    prev_tone   = tone_out;
    prev_active = active;
    prev_note   = cur_note;
  end

  initial begin
    int g4;
    int bad;
    g4       = int'(model_hp(7, 4));
    reset    = 1'b1;
    key_on   = 1'b0;
    note_sel = 4'd0;
    octave   = 3'd4;
    repeat (3) @(negedge clk);
    chk("rst_tone", 64'(tone_out), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_edge", 64'(edge_tick), 64'd0);
    chk("rst_note", 64'(cur_note), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // G4 steady tone over three periods
    note_sel = 4'd7;
    octave   = 3'd4;
    for (int i = 0; i < 3; i++) push_period(7, 4);
    key_on = 1'b1;
    wait_q(1, 6 * g4 + 20, "g4_run");
    chk("g4_active", 64'(active), 64'd1);
    chk("g4_cur_note", 64'(cur_note), 64'd7);
    key_on = 1'b0;
    wait_idle(g4 + 20, "g4_release");
    chk("g4_drained", 64'(exp_q.size()), 64'd0);

    // Octave scaling, including the longest half-period at octave 0
    play(9, 4, 1);
    play(9, 5, 2);
    play(9, 3, 1);
    play(9, 7, 2);
    play(0, 0, 1);
    play(11, 6, 2);

    // Pitch change mid-high-half applies only at the next period
    note_sel = 4'd7;
    octave   = 3'd4;
    push_period(7, 4);
    push_period(9, 4);
    key_on = 1'b1;
    repeat (300) @(negedge clk);
    note_sel = 4'd9;
    wait_q(1, 4 * g4 + 20, "chg_run");
    key_on = 1'b0;
    wait_idle(g4 + 20, "chg_release");
    chk("chg_drained", 64'(exp_q.size()), 64'd0);

    // Release early in the high half: full period completes, then idle
    note_sel = 4'd7;
    push_period(7, 4);
    key_on = 1'b1;
    repeat (10) @(negedge clk);
    key_on = 1'b0;
    wait_idle(2 * g4 + 20, "rel_idle");
    chk("rel_drained", 64'(exp_q.size()), 64'd0);
    repeat (50) @(negedge clk);
    chk("rel_stays_low", 64'(tone_out | active), 64'd0);

    // Release then reassert inside the low half: no gap
    push_period(7, 4);
    push_period(7, 4);
    key_on = 1'b1;
    repeat (10) @(negedge clk);
    key_on = 1'b0;
    wait_q(3, g4 + 20, "reass_high_done");
    key_on = 1'b1;
    wait_q(2, g4 + 20, "reass_low_done");
    chk("reass_active", 64'(active), 64'd1);
    chk("reass_tone", 64'(tone_out), 64'd1);
    wait_q(1, g4 + 20, "reass_run");
    key_on = 1'b0;
    wait_idle(g4 + 20, "reass_release");
    chk("reass_drained", 64'(exp_q.size()), 64'd0);

    // Rest code from idle never starts a note
    note_sel = 4'd13;
    key_on   = 1'b1;
    bad      = 0;
    repeat (60) begin
      @(negedge clk);
      if (active || tone_out || edge_tick) bad++;
    end
    chk("rest_idle", 64'(bad), 64'd0);
    key_on = 1'b0;

    // Rest code mid-play acts as release at the boundary
    note_sel = 4'd9;
    push_period(9, 4);
    key_on = 1'b1;
    repeat (10) @(negedge clk);
    note_sel = 4'd12;
    wait_idle(2 * g4 + 20, "rest_mid_idle");
    chk("rest_mid_drained", 64'(exp_q.size()), 64'd0);
    key_on = 1'b0;
    @(negedge clk);

    // Synchronous reset mid-high-half, then restart with key still held
    mon_en = 1'b0;
    exp_q.delete();
    note_sel = 4'd7;
    key_on   = 1'b1;
    repeat (100) @(negedge clk);
    chk("pre_rst_tone", 64'(tone_out), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tone", 64'(tone_out), 64'd0);
    chk("mid_rst_active", 64'(active), 64'd0);
    chk("mid_rst_note", 64'(cur_note), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_active", 64'(active), 64'd1);
    chk("restart_tone", 64'(tone_out), 64'd1);
    chk("restart_edge", 64'(edge_tick), 64'd1);
    chk("restart_note", 64'(cur_note), 64'd7);
    key_on = 1'b0;
    wait_idle(2 * g4 + 20, "restart_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
